// File: rtl/MD_pkg.sv
// Shared MD datapath widths plus the force-cache drain FSM state and FIFO entry types.
package MD_pkg;

    localparam int PARTICLE_ID_WIDTH  = 5;
    localparam int FLOAT_WIDTH        = 32;
    localparam int FLOAT_STRUCT_WIDTH = 3 * FLOAT_WIDTH;

    typedef enum logic [2:0] {
        DRAIN_IDLE       = 3'd0,
        DRAIN_WAIT_QUIET = 3'd1,
        DRAIN_ISSUE      = 3'd2,
        DRAIN_FLUSH      = 3'd3,
        DRAIN_DONE       = 3'd4
    } drain_state_t;

    typedef struct packed {
        logic [FLOAT_STRUCT_WIDTH-1:0] frc;
        logic [PARTICLE_ID_WIDTH-1:0]  parid;
    } frc_parid_t;

endpackage

// File: rtl/frc_drain_fifo.sv
// First-word-fall-through FIFO of tagged forces; count lets the reader budget in-flight reads.
module frc_drain_fifo
    import MD_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  frc_parid_t               push_data,
    input  logic                     pop,
    output frc_parid_t               head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    frc_parid_t     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           full;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/frc_cache_drain_ctrl.sv
// Drains the force cache after the force pipeline goes quiet and streams tagged forces
// to motion update, throttling reads so the output FIFO can never overflow.
//   state       | meaning
//   IDLE        | waiting for i_start
//   WAIT_QUIET  | counting consecutive quiet cycles
//   ISSUE       | issuing clear-on-read requests for IDs 0..N-1
//   FLUSH       | waiting for last return and FIFO to drain
//   DONE        | one-cycle completion pulse
module frc_cache_drain_ctrl
    import MD_pkg::*;
#(
    parameter int OUT_FIFO_DEPTH = 8,
    parameter int QUIET_CYCLES   = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic [PARTICLE_ID_WIDTH:0]    i_num_particles,
    input  logic                          i_frc_evals_done,
    input  logic                          i_cache_buf_empty,
    output logic [PARTICLE_ID_WIDTH-1:0]  o_MU_rd_addr,
    output logic                          o_MU_rd_en,
    input  logic [FLOAT_STRUCT_WIDTH-1:0] i_frc,
    input  logic                          i_frc_valid,
    output logic [FLOAT_STRUCT_WIDTH-1:0] o_frc,
    output logic [PARTICLE_ID_WIDTH-1:0]  o_frc_parid,
    output logic                          o_frc_valid,
    input  logic                          i_frc_ready,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_err
);

    localparam int CW = $clog2(OUT_FIFO_DEPTH) + 1;
    localparam int QW = $clog2(QUIET_CYCLES + 1);

    drain_state_t                 state;
    drain_state_t                 state_nxt;
    logic [PARTICLE_ID_WIDTH:0]   n_lat;
    logic [PARTICLE_ID_WIDTH:0]   addr_cnt;
    logic [QW-1:0]                quiet_cnt;
    logic [PARTICLE_ID_WIDTH-1:0] addr_d1;
    logic                         rd_en_d1;
    logic                         quiet;
    logic                         quiet_last;
    logic                         credit_ok;
    logic                         last_rd;
    logic [CW-1:0]                fifo_count;
    logic                         fifo_empty;
    frc_parid_t                   fifo_head;
    frc_parid_t                   push_data;
    logic                         push;
    logic                         pop;

    assign quiet      = i_frc_evals_done & i_cache_buf_empty;
    assign quiet_last = quiet && (quiet_cnt == QW'(QUIET_CYCLES - 1));
    // A read issued now lands next cycle; the one issued last cycle is landing now.
    assign credit_ok  = ({1'b0, fifo_count} + (CW+1)'(rd_en_d1)) < (CW+1)'(OUT_FIFO_DEPTH);
    assign o_MU_rd_en = (state == DRAIN_ISSUE) && credit_ok;
    assign o_MU_rd_addr = addr_cnt[PARTICLE_ID_WIDTH-1:0];
    assign last_rd    = o_MU_rd_en && (addr_cnt == n_lat - 1'b1);

    always_comb begin
        state_nxt = state;
        case (state)
            DRAIN_IDLE:       if (i_start) state_nxt = DRAIN_WAIT_QUIET;
            DRAIN_WAIT_QUIET: if (quiet_last)
                                  state_nxt = (n_lat == '0) ? DRAIN_DONE : DRAIN_ISSUE;
            DRAIN_ISSUE:      if (last_rd) state_nxt = DRAIN_FLUSH;
            DRAIN_FLUSH:      if (!rd_en_d1 && fifo_empty) state_nxt = DRAIN_DONE;
            DRAIN_DONE:       state_nxt = DRAIN_IDLE;
            default:          state_nxt = DRAIN_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DRAIN_IDLE;
            n_lat     <= '0;
            addr_cnt  <= '0;
            quiet_cnt <= '0;
            rd_en_d1  <= 1'b0;
            addr_d1   <= '0;
            o_err     <= 1'b0;
        end else begin
            state    <= state_nxt;
            rd_en_d1 <= o_MU_rd_en;
            addr_d1  <= o_MU_rd_addr;
            if (state == DRAIN_IDLE && i_start) begin
                n_lat    <= i_num_particles;
                addr_cnt <= '0;
            end else if (o_MU_rd_en) begin
                addr_cnt <= addr_cnt + 1'b1;
            end
            if (state == DRAIN_WAIT_QUIET && quiet) quiet_cnt <= quiet_cnt + 1'b1;
            else                                    quiet_cnt <= '0;
            if (i_frc_valid && !rd_en_d1) o_err <= 1'b1;
        end
    end

    assign push            = i_frc_valid & rd_en_d1;
    assign push_data.frc   = i_frc;
    assign push_data.parid = addr_d1;
    assign pop             = o_frc_valid & i_frc_ready;

    frc_drain_fifo #(
        .DEPTH (OUT_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign o_frc_valid = ~fifo_empty;
    assign o_frc       = fifo_empty ? '0 : fifo_head.frc;
    assign o_frc_parid = fifo_empty ? '0 : fifo_head.parid;
    assign o_busy      = (state != DRAIN_IDLE);
    assign o_done      = (state == DRAIN_DONE);

endmodule

// File: tb/tb_frc_cache_drain_ctrl.sv
// Scoreboard bench for the force-cache drain controller with a one-cycle-latency cache model.
module tb_frc_cache_drain_ctrl;
    import MD_pkg::*;

    localparam int PIW = PARTICLE_ID_WIDTH;
    localparam int FSW = FLOAT_STRUCT_WIDTH;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           i_start = 1'b0;
    logic [PIW:0]   i_num_particles = '0;
    logic           i_frc_evals_done = 1'b0;
    logic           i_cache_buf_empty = 1'b0;
    logic [PIW-1:0] o_MU_rd_addr;
    logic           o_MU_rd_en;
    logic [FSW-1:0] i_frc = '0;
    logic           i_frc_valid = 1'b0;
    logic [FSW-1:0] o_frc;
    logic [PIW-1:0] o_frc_parid;
    logic           o_frc_valid;
    logic           i_frc_ready = 1'b0;
    logic           o_busy;
    logic           o_done;
    logic           o_err;

    always #5 clk = ~clk;

    frc_cache_drain_ctrl #(
        .OUT_FIFO_DEPTH (8),
        .QUIET_CYCLES   (6)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_start           (i_start),
        .i_num_particles   (i_num_particles),
        .i_frc_evals_done  (i_frc_evals_done),
        .i_cache_buf_empty (i_cache_buf_empty),
        .o_MU_rd_addr      (o_MU_rd_addr),
        .o_MU_rd_en        (o_MU_rd_en),
        .i_frc             (i_frc),
        .i_frc_valid       (i_frc_valid),
        .o_frc             (o_frc),
        .o_frc_parid       (o_frc_parid),
        .o_frc_valid       (o_frc_valid),
        .i_frc_ready       (i_frc_ready),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_err             (o_err)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [FSW-1:0] frc_of(input int a);
        logic [31:0] x;
        case (a)
            0:       x = 32'h3F80_0000;
            1:       x = 32'h4000_0000;
            2:       x = 32'h4040_0000;
            3:       x = 32'h4080_0000;
            default: x = 32'h4200_0000 | 32'(a);
        endcase
        return {32'hC000_0000 | 32'(a), 32'h4100_0000 | 32'(a), x};
    endfunction

    // cache model: sample the request mid-cycle, answer one cycle later
    logic           pend_v = 1'b0;
    logic [PIW-1:0] pend_a = '0;
    logic           inject_err = 1'b0;

    always @(negedge clk) begin
        pend_v = o_MU_rd_en;
        pend_a = o_MU_rd_addr;
    end

    always @(posedge clk) begin
        #1;
        i_frc_valid = pend_v | inject_err;
        i_frc       = frc_of(int'(pend_a));
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    frc_parid_t     exp_q[$];
    int             c0 = 0;
    int             rd_count = 0;
    int             out_cnt = 0;
    int             done_cnt = 0;
    int             done_cyc = -1;
    int             first_rd = -1;
    int             last_rd = -1;
    int             first_valid = -1;
    logic [PIW-1:0] exp_addr = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (o_MU_rd_en) begin
                chk("rd_addr", o_MU_rd_addr, exp_addr);
                exp_addr = exp_addr + 1'b1;
                if (rd_count == 0) first_rd = cyc - c0;
                last_rd = cyc - c0;
                rd_count++;
            end
            if (o_frc_valid && first_valid < 0) first_valid = cyc - c0;
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc - c0;
            end
            if (o_frc_valid && i_frc_ready) begin
                if (exp_q.size() == 0) begin
                    chk("out_extra", exp_q.size(), 1);
                end else begin
                    frc_parid_t e;
                    e = exp_q.pop_front();
                    chk("out_parid", o_frc_parid, e.parid);
                    chk("out_frc", o_frc, e.frc);
                end
                out_cnt++;
            end
        end
    end

    task automatic start_drain(input int n);
        @(posedge clk);
        #1;
        rd_count    = 0;
        out_cnt     = 0;
        first_rd    = -1;
        last_rd     = -1;
        first_valid = -1;
        done_cyc    = -1;
        exp_addr    = '0;
        for (int i = 0; i < n; i++) exp_q.push_back('{frc: frc_of(i), parid: PIW'(i)});
        c0              = cyc;
        i_start         = 1'b1;
        i_num_particles = (PIW+1)'(n);
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < max_cyc) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk(tag, done_cnt - d0, 1);
        chk({tag, "_busy"}, o_busy, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int snap;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", o_MU_rd_en, 1'b0);
        chk("rst_rd_addr", o_MU_rd_addr, '0);
        chk("rst_valid", o_frc_valid, 1'b0);
        chk("rst_frc", o_frc, '0);
        chk("rst_parid", o_frc_parid, '0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_err", o_err, 1'b0);
        rst = 1'b0;
        i_frc_evals_done  = 1'b1;
        i_cache_buf_empty = 1'b1;
        i_frc_ready       = 1'b1;
        repeat (2) @(posedge clk);

        // N=4, ready high, quiet from c1
        start_drain(4);
        wait_done("n4_done", 60);
        chk("n4_first_rd", first_rd, 7);
        chk("n4_last_rd", last_rd, 10);
        chk("n4_rd_count", rd_count, 4);
        chk("n4_first_valid", first_valid, 9);
        chk("n4_out_cnt", out_cnt, 4);
        chk("n4_done_cyc", done_cyc, 14);
        chk("n4_q_empty", exp_q.size(), 0);

        // quiet window broken at its 4th cycle
        start_drain(2);
        repeat (3) @(posedge clk);
        #1;
        i_cache_buf_empty = 1'b0;
        @(posedge clk);
        #1;
        i_cache_buf_empty = 1'b1;
        wait_done("gate_done", 60);
        chk("gate_first_rd", first_rd, 11);
        chk("gate_out_cnt", out_cnt, 2);

        // backpressure: N=20 against an 8-entry FIFO
        i_frc_ready = 1'b0;
        start_drain(20);
        repeat (40) @(posedge clk);
        #1;
        chk("bp_stall_reads", rd_count, 8);
        chk("bp_valid", o_frc_valid, 1'b1);
        chk("bp_head_parid", o_frc_parid, '0);
        chk("bp_busy", o_busy, 1'b1);
        i_frc_ready = 1'b1;
        wait_done("bp_done", 200);
        chk("bp_rd_count", rd_count, 20);
        chk("bp_out_cnt", out_cnt, 20);
        chk("bp_q_empty", exp_q.size(), 0);

        // N=0
        start_drain(0);
        wait_done("n0_done", 40);
        chk("n0_done_cyc", done_cyc, 7);
        chk("n0_rd_count", rd_count, 0);
        chk("n0_out_cnt", out_cnt, 0);

        // stray return in IDLE, then start ignored while busy
        @(negedge clk);
        inject_err = 1'b1;
        @(negedge clk);
        inject_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("err_set", o_err, 1'b1);
        start_drain(3);
        i_start         = 1'b1;
        i_num_particles = (PIW+1)'(9);
        @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_done("busy_done", 60);
        chk("busy_rd_count", rd_count, 3);
        chk("busy_out_cnt", out_cnt, 3);
        chk("err_sticky", o_err, 1'b1);

        // reset mid-ISSUE after 3 reads
        start_drain(10);
        k = 0;
        while (rd_count < 3 && k < 50) begin
            @(posedge clk);
            k++;
        end
        chk("mid_reached", rd_count, 3);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rd_en", o_MU_rd_en, 1'b0);
        chk("mid_rd_addr", o_MU_rd_addr, '0);
        chk("mid_valid", o_frc_valid, 1'b0);
        chk("mid_frc", o_frc, '0);
        chk("mid_parid", o_frc_parid, '0);
        chk("mid_busy", o_busy, 1'b0);
        chk("mid_done", o_done, 1'b0);
        chk("mid_err", o_err, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        snap = rd_count;
        repeat (30) @(posedge clk);
        #1;
        chk("mid_no_reads", rd_count, snap);
        chk("mid_idle", o_busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
